debounce_bank: RTL and testbench
================================

// Module: debounce_bank
// PURPOSE
//   Multi-channel, parametrised key debouncer for the Morse front end.
//   - Each channel: input synchroniser, polarity normalisation, stable-count filter.
//   - Per-channel one-cycle press/release pulses so the Morse FSM needs no edge detectors.
//   - Optional per-channel hold-duration measurement for dot/dash classification.
// PARAMETERS
//   CHANNELS        4       number of independent key inputs (>=1)
//   CNT_W           20      debounce counter width
//   DEBOUNCE_LIMIT  539999  extra stable samples required; must be < 2**CNT_W
//   ACTIVE_LOW_MASK 0       CHANNELS-bit mask; bit=1 -> that input is pressed when 0
//   SYNC_STAGES     2       synchroniser flops per input (>=2)
//   HOLD_W          16      hold-duration counter width
//   HOLD_TICK       27000   clk cycles per hold tick (>=1)
// PORTS
//   clk            in   1              system clock
//   rst_n          in   1              asynchronous, active-low reset
//   btn_in         in   CHANNELS       raw asynchronous key inputs
//   btn_out        out  CHANNELS       debounced level, 1 = pressed (polarity normalised)
//   press_pulse    out  CHANNELS       1-cycle pulse on accepted press
//   release_pulse  out  CHANNELS       1-cycle pulse on accepted release
//   hold_len       out  CHANNELS*HOLD_W  last press duration in ticks; ch n at [n*HOLD_W +: HOLD_W]
//   hold_valid     out  CHANNELS       1-cycle pulse: hold_len[n] updated
// BEHAVIOUR
//   - Reset is asynchronous and active-low on rst_n; clock is clk.
//   - Reset values:
//     - Sync flops = released level (1 if ACTIVE_LOW_MASK bit set, else 0).
//     - Debounced state, counters, prescaler, all outputs = 0.
//   - Normalisation: norm[n] = sync_out[n] ^ ACTIVE_LOW_MASK[n].
//   - Per-channel filter, evaluated every clk edge:
//     - norm == state:
//       - counter <= 0.
//     - norm != state and counter == DEBOUNCE_LIMIT:
//       - state <= norm; counter <= 0.
//       - press_pulse (0->1) or release_pulse (1->0) asserted the same cycle btn_out changes.
//     - Otherwise: counter <= counter + 1.
//   - Acceptance requires DEBOUNCE_LIMIT+1 consecutive mismatching samples.
//     - Any matching sample restarts the count.
//     - DEBOUNCE_LIMIT=0 accepts on the first mismatching sample.
//   - Latency: input first sampled at edge E0 -> btn_out changes at edge E0+SYNC_STAGES+DEBOUNCE_LIMIT.
//   - Channels are fully independent:
//     - Simultaneous events on several channels pulse in the same cycle.
//     - press_pulse and release_pulse are never both set for one channel.
//   - Counter never exceeds DEBOUNCE_LIMIT, so it never wraps.
//   - rst_n asserted mid-count: everything clears immediately; no pulse emitted on reset entry or exit.
//   - Input pressed through reset release: press accepted after full latency; press_pulse fires normally.
// CONFIGURATION
//   DEBOUNCE_HOLD_TIMER_EN defined:
//     - Shared free-running prescaler emits a tick every HOLD_TICK cycles.
//     - Per-channel hold counter:
//       - Cleared in the cycle press_pulse fires.
//       - +1 per tick while btn_out=1; saturates at 2**HOLD_W-1 (no wrap).
//     - On release accept: hold_len[n] <= hold counter value (including a tick landing that cycle).
//       - hold_valid[n] pulses coincident with release_pulse[n].
//       - hold_len holds its value until the next release.
//   DEBOUNCE_HOLD_TIMER_EN undefined:
//     - hold_len and hold_valid are tied to 0.
//     - No prescaler or hold counters are synthesised; ports remain present.
// TESTING  (CHANNELS=4, DEBOUNCE_LIMIT=3, SYNC_STAGES=2 unless stated)
//   1. Reset: rst_n=0 with btn_in=4'hF -> btn_out, pulses, hold_len, hold_valid all 0; stays 0 while rst_n=0.
//   2. Clean press: btn_in[0] 0->1 sampled at E0 -> btn_out[0]=1 and press_pulse[0]=1 at E0+5.
//      - press_pulse[0] is 1 for exactly one cycle; release gives release_pulse[0] at E0+5 likewise.
//   3. Glitch filter on ch0:
//      - 3-cycle high pulse -> no btn_out change, no pulses.
//      - 4-cycle high pulse -> accepted press, then accepted release.
//   4. Polarity: ACTIVE_LOW_MASK=4'b0010, btn_in[1] idle=1 -> btn_out[1]=0.
//      - Drive btn_in[1]=0 -> btn_out[1]=1 and press_pulse[1] after 5 cycles.
//   5. Simultaneous: all four inputs rise on the same edge -> press_pulse=4'hF in one cycle.
//      - Then release ch2 only -> release_pulse=4'b0100; other channels unaffected.
//   6. Hold timer (macro on, HOLD_TICK=4, HOLD_W=4):
//      - 40-cycle press -> hold_valid[0] pulse, hold_len[0]=10 +/-1.
//      - 100-cycle press -> hold_len[0]=15 (saturated).
//      - rst_n pulsed mid-press -> no hold_valid.

Source files
------------

// File: rtl/debounce_bank.sv
// Multi-channel key debouncer: synchroniser, polarity normalisation, stable-count filter, pulses.
// Define DEBOUNCE_HOLD_TIMER_EN to build the per-channel hold-duration timer.
module debounce_bank #(
  parameter int unsigned          CHANNELS        = 4,
  parameter int unsigned          CNT_W           = 20,
  parameter int unsigned          DEBOUNCE_LIMIT  = 539999,
  parameter logic [CHANNELS-1:0]  ACTIVE_LOW_MASK = '0,
  parameter int unsigned          SYNC_STAGES     = 2,
  parameter int unsigned          HOLD_W          = 16,
  parameter int unsigned          HOLD_TICK       = 27000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CHANNELS-1:0]        btn_in,
  output logic [CHANNELS-1:0]        btn_out,
  output logic [CHANNELS-1:0]        press_pulse,
  output logic [CHANNELS-1:0]        release_pulse,
  output logic [CHANNELS*HOLD_W-1:0] hold_len,
  output logic [CHANNELS-1:0]        hold_valid
);

  if (CHANNELS < 1 || SYNC_STAGES < 2 || HOLD_TICK < 1 || HOLD_W < 1) begin : g_param_check
    $error("debounce_bank: illegal parameter value");
  end

  localparam logic [CNT_W-1:0] Limit = CNT_W'(DEBOUNCE_LIMIT);

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_d [SYNC_STAGES];
  logic [CHANNELS-1:0] norm;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] state_q, state_d;
  logic [CHANNELS-1:0] press_q, press_d;
  logic [CHANNELS-1:0] rel_q, rel_d;

  always_comb begin
    sync_d[0] = btn_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // Synchroniser resets to the released level so reset exit never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= ACTIVE_LOW_MASK;
      end
    end else begin
      sync_q <= sync_d;
    end
  end

  assign norm = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW_MASK;

  always_comb begin
    state_d = state_q;
    press_d = '0;
    rel_d   = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      cnt_d[n] = '0;
      if (norm[n] != state_q[n]) begin
        if (cnt_q[n] == Limit) begin
          state_d[n] = norm[n];
          press_d[n] = norm[n];
          rel_d[n]   = ~norm[n];
        end else begin
          cnt_d[n] = cnt_q[n] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < CHANNELS; n++) begin
        cnt_q[n] <= '0;
      end
      state_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign btn_out       = state_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;

`ifdef DEBOUNCE_HOLD_TIMER_EN
  localparam int unsigned PreW = (HOLD_TICK > 1) ? $clog2(HOLD_TICK) : 1;

  logic [PreW-1:0]     pre_q, pre_d;
  logic                tick;
  logic [HOLD_W-1:0]   hcnt_q [CHANNELS];
  logic [HOLD_W-1:0]   hcnt_d [CHANNELS];
  logic [HOLD_W-1:0]   hinc   [CHANNELS];
  logic [HOLD_W-1:0]   hlen_q [CHANNELS];
  logic [HOLD_W-1:0]   hlen_d [CHANNELS];
  logic [CHANNELS-1:0] hval_q, hval_d;

  // hinc folds in a tick landing on the release cycle so it is captured in hold_len.
  always_comb begin
    tick   = (pre_q == PreW'(HOLD_TICK - 1));
    pre_d  = tick ? '0 : pre_q + 1'b1;
    hval_d = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      hinc[n]   = (tick && (hcnt_q[n] != '1)) ? hcnt_q[n] + 1'b1 : hcnt_q[n];
      hcnt_d[n] = state_q[n] ? hinc[n] : hcnt_q[n];
      hlen_d[n] = hlen_q[n];
      if (press_d[n]) begin
        hcnt_d[n] = '0;
      end
      if (rel_d[n]) begin
        hlen_d[n] = hinc[n];
        hval_d[n] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      hval_q <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        hcnt_q[n] <= '0;
        hlen_q[n] <= '0;
      end
    end else begin
      pre_q  <= pre_d;
      hval_q <= hval_d;
      hcnt_q <= hcnt_d;
      hlen_q <= hlen_d;
    end
  end

  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      hold_len[n*HOLD_W +: HOLD_W] = hlen_q[n];
    end
  end
  assign hold_valid = hval_q;
`else
  assign hold_len   = '0;
  assign hold_valid = '0;
`endif

endmodule

// File: tb/tb_debounce_bank.sv
// Randomised scoreboard bench for debounce_bank: a sample-history reference model predicts
// level changes and pulse events; a negedge monitor pops and compares them.
module tb_debounce_bank;
  localparam int         CH   = 4;
  localparam int         LIM  = 3;
  localparam int         SYNC = 2;
  localparam int         HW   = 4;
  localparam int         HT   = 4;
  localparam logic [3:0] ALM  = 4'b0010;
  localparam logic [3:0] IDLE = ALM;
`ifdef DEBOUNCE_HOLD_TIMER_EN
  localparam bit HoldEn = 1'b1;
`else
  localparam bit HoldEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  btn_in = 4'hF;
  logic [3:0]  btn_out, press_pulse, release_pulse, hold_valid;
  logic [15:0] hold_len;

  debounce_bank #(
    .CHANNELS        (CH),
    .CNT_W           (4),
    .DEBOUNCE_LIMIT  (LIM),
    .ACTIVE_LOW_MASK (ALM),
    .SYNC_STAGES     (SYNC),
    .HOLD_W          (HW),
    .HOLD_TICK       (HT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_in        (btn_in),
    .btn_out       (btn_out),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .hold_len      (hold_len),
    .hold_valid    (hold_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] pr;
    logic [3:0] rl;
    logic [3:0] hv;
  } ev_t;

  ev_t         expq[$];
  ev_t         e;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  // Reference model: input delayed by SYNC samples, accept after LIM+1 mismatching samples.
  logic [3:0]  hist[$];
  logic [3:0]  m_level;
  int          m_run  [CH];
  int          m_hold [CH];
  logic [15:0] m_hlen;
  int          m_pre;
  int          tick;
  logic [3:0]  seen, pr, rl, old_level;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < SYNC; i++) hist.push_back(4'b0);
    m_level = '0;
    m_hlen  = '0;
    m_pre   = 0;
    for (int c = 0; c < CH; c++) begin
      m_run[c]  = 0;
      m_hold[c] = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        cyc++;
        hist.push_back(btn_in ^ ALM);
        seen  = hist.pop_front();
        tick  = (m_pre == HT - 1) ? 1 : 0;
        m_pre = (tick == 1) ? 0 : m_pre + 1;
        pr = '0;
        rl = '0;
        old_level = m_level;
        for (int c = 0; c < CH; c++) begin
          if (seen[c] != m_level[c]) begin
            m_run[c]++;
            if (m_run[c] == LIM + 1) begin
              m_level[c] = seen[c];
              m_run[c]   = 0;
              if (seen[c]) pr[c] = 1'b1;
              else         rl[c] = 1'b1;
            end
          end else begin
            m_run[c] = 0;
          end
          if (old_level[c]) m_hold[c] = (m_hold[c] + tick > 15) ? 15 : m_hold[c] + tick;
          if (rl[c]) m_hlen[c*HW +: HW] = 4'(m_hold[c]);
          if (pr[c]) m_hold[c] = 0;
        end
        if ((pr | rl) != 4'b0) expq.push_back('{cyc, pr, rl, HoldEn ? rl : 4'b0});
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("btn_out", 32'(btn_out), 32'(m_level));
      chk("hold_len", 32'(hold_len), HoldEn ? 32'(m_hlen) : 32'd0);
      while (expq.size() > 0 && expq[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL missing_event: got none expected pr=%0h rl=%0h at cycle %0d",
                 expq[0].pr, expq[0].rl, expq[0].cyc);
        void'(expq.pop_front());
      end
      if ((press_pulse | release_pulse | hold_valid) != 4'b0) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: got pr=%0h rl=%0h hv=%0h expected none (cycle %0d)",
                   press_pulse, release_pulse, hold_valid, cyc);
        end else begin
          e = expq.pop_front();
          chk("event_cycle", 32'(cyc), 32'(e.cyc));
          chk("press_pulse", 32'(press_pulse), 32'(e.pr));
          chk("release_pulse", 32'(release_pulse), 32'(e.rl));
          chk("hold_valid", 32'(hold_valid), 32'(e.hv));
        end
      end
    end
  end

  task automatic hold_for(input logic [3:0] v, input int n);
    btn_in = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    btn_in = 4'hF;
    rst_n  = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    hold_for(4'hF, 12);
    // clean press/release, then 3- and 4-sample glitches on ch0
    hold_for(IDLE, 10);
    hold_for(IDLE | 4'b0001, 10);
    hold_for(IDLE, 10);
    hold_for(IDLE | 4'b0001, 3);
    hold_for(IDLE, 10);
    hold_for(IDLE | 4'b0001, 4);
    hold_for(IDLE, 10);
    // active-low ch1 press, simultaneous press, release ch2 only
    hold_for(4'b0000, 10);
    hold_for(IDLE, 10);
    hold_for(4'b1101, 10);
    hold_for(4'b1001, 10);
    hold_for(IDLE, 10);
    // hold durations: nominal and saturating
    hold_for(IDLE | 4'b0001, 40);
    hold_for(IDLE, 10);
    hold_for(IDLE | 4'b0001, 100);
    hold_for(IDLE, 10);
    for (int i = 0; i < 400; i++) begin
      hold_for(4'($urandom), $urandom_range(1, 8));
    end
    hold_for(IDLE, 10);
    // reset landing mid-press, between clock edges
    hold_for(IDLE | 4'b0001, 20);
    #2 rst_n = 1'b0;
    @(negedge clk);
    hold_for(IDLE | 4'b0001, 3);
    rst_n = 1'b1;
    hold_for(IDLE | 4'b0001, 20);
    hold_for(IDLE, 20);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
